tile_spawner: RTL and testbench
===============================

TILE_SPAWNER -- requirements
Module: tile_spawner

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous reset, active low).
REQ-002 The module SHALL have these data and control ports:
- start, input, 1: one-cycle request; a slide has just completed.
- new_game, input, 1: one-cycle request; clear the board and spawn two tiles.
- board_prev, input, [15:0][3:0]: board before the slide.
- board_in, input, [15:0][3:0]: board produced by the slide stage.
- board_out, output, [15:0][3:0]: board after the spawn.
- busy, output, 1: high whenever the FSM is not in IDLE.
- done, output, 1: one-cycle pulse; board_out and the flags are updated.
- win, output, 1: sticky flag.
- game_over, output, 1: sticky flag.
REQ-003 Cell encoding SHALL be: 0 = empty; n = tile value 2^n; win value = 4'd11.

Function
REQ-004 A free-running 16-bit Fibonacci LFSR SHALL step every clock. Its polynomial is x^16+x^14+x^13+x^11+1 and its reset seed is 16'hACE1.
REQ-005 The FSM SHALL have five states: IDLE, LOAD, SEARCH, CHECK, DONE.
REQ-006 start and new_game SHALL be accepted only in IDLE and ignored otherwise. If both are high, new_game wins.
REQ-007 LOAD (one cycle) SHALL perform these actions:
- Latch the working board: board_in for start; all zeros for new_game.
- Set changed = (board_in != board_prev); changed is forced to 1 for new_game.
- Latch ptr = lfsr[3:0].
- Latch val = 2 if lfsr[7:4] == 4'hF, else 1.
- Clear the probe counter.
- If changed = 0, go to CHECK; otherwise go to SEARCH.
REQ-008 SEARCH SHALL probe one cell per cycle.
- If work[ptr] == 0: write val there and go to CHECK.
- Otherwise: ptr = ptr+1 modulo 16 (15 wraps to 0) and probe_count increments.
- After 16 non-empty probes, go to CHECK with no write.
REQ-009 SEARCH latency SHALL be 1..16 cycles. Total start-to-done SHALL be 3..19 cycles: 3 when there is no change.
REQ-010 For new_game, SEARCH SHALL run twice. Between the passes, ptr and val SHALL be re-latched from the current LFSR, so exactly two distinct cells become nonzero.
REQ-011 CHECK (one cycle) SHALL evaluate the working board combinationally:
- win_next = any cell == 11.
- game_over_next = no cell == 0 AND no horizontally or vertically adjacent pair is equal.
- Row r, column c maps to index 4r+c. Horizontal neighbours never cross a row boundary (no 3 to 4 wrap).
REQ-012 On entering DONE, the module SHALL:
- Copy the working board to board_out.
- OR win_next into win.
- OR game_over_next into game_over.
- Pulse done for exactly one cycle, then return to IDLE.
REQ-013 board_out SHALL change only on the DONE cycle and hold its value otherwise.
REQ-014 win and game_over SHALL clear only on reset or on new_game acceptance in LOAD. Once game_over = 1, start SHALL still run normally: the board passes through unchanged.
REQ-015 Arithmetic: ptr and probe_count SHALL be 4-bit and 5-bit respectively. No tile value is incremented by this block.

Reset
REQ-016 While rst_n = 0, the following SHALL apply:
- State = IDLE.
- board_out = 0, busy = 0, done = 0, win = 0, game_over = 0.
- LFSR = 16'hACE1.
- Working registers = 0.
REQ-017 Reset asserted mid-LOAD, mid-SEARCH or mid-CHECK SHALL abort the operation. No done pulse is produced and no partial board reaches board_out.
REQ-018 After reset deassertion, the first accepted request SHALL be processed normally. The first LOAD occurs on the second clock edge after start is sampled high.

Structure
REQ-019 A shared package game_pkg SHALL hold the following:
- typedef cell_t (4 bits).
- typedef board_t ([15:0] cell_t).
- CELL_EMPTY = 0.
- CELL_WIN = 11.
- LFSR_SEED = 16'hACE1.
- The spawner state enum.
REQ-020 One sub-module, lfsr16 (clk, rst_n, q[15:0]), SHALL be instantiated. All other logic SHALL be in tile_spawner.

Verification
REQ-021 Unchanged board: board_in = board_prev = {cell0 = 1, rest 0}, then start -> done exactly 3 cycles later; board_out = board_in; busy high for 3 cycles.
REQ-022 Single empty cell: all cells 1..15 (non-matching pattern) except cell 9 = 0, board_prev differing -> board_out[9] ∈ {1,2}; all other cells unchanged; done within 19 cycles.
REQ-023 Full board, no merges: checkerboard of 1/2, changed -> 16 probes with no write, done at cycle 19, game_over = 1, win = 0.
REQ-024 Win: board_in contains cell5 = 11 plus empties -> win = 1 on done, remaining 1 after a subsequent unchanged start.
REQ-025 new_game after reset -> exactly two nonzero cells, each 1 or 2; win = 0 and game_over = 0; start pulsed during busy is ignored (done count = 1).
REQ-026 Reset mid-SEARCH: rst_n low 1 cycle during the 2nd SEARCH cycle -> board_out = 0, busy = 0, and no done pulse within the next 20 cycles absent start.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the 2048-style board pipeline.
// Cells hold log2 of the tile value; 0 marks an empty cell.
package game_pkg;

  typedef logic [3:0] cell_t;
  typedef cell_t [15:0] board_t;

  localparam cell_t       CELL_EMPTY = 4'd0;
  localparam cell_t       CELL_WIN   = 4'd11;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } spawn_state_e;

  // A spawned tile is a 4 (code 2) one time in sixteen, otherwise a 2 (code 1).
  function automatic cell_t spawn_val(input logic [3:0] sel);
    return (sel == 4'hF) ? 4'd2 : 4'd1;
  endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Request/response bundle between the slide stage and the tile spawner.
interface tile_spawner_if;
  import game_pkg::*;

  logic   start;
  logic   new_game;
  board_t board_prev;
  board_t board_in;
  board_t board_out;
  logic   busy;
  logic   done;
  logic   win;
  logic   game_over;

  modport master (
    output start, new_game, board_prev, board_in,
    input  board_out, busy, done, win, game_over
  );

  modport slave (
    input  start, new_game, board_prev, board_in,
    output board_out, busy, done, win, game_over
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Feedback from taps 16/14/13/11 enters at the top as the register shifts right.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Shift register state, seeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/tile_spawner.sv
// Drops a new tile into a random empty cell after each slide (two on a new game)
// and keeps the sticky win / game-over flags.
module tile_spawner
  import game_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  tile_spawner_if.slave  bus
);

  logic [15:0]  lfsr_s;

  spawn_state_e state_q,     state_d;
  board_t       work_q,      work_d;
  logic [3:0]   ptr_q,       ptr_d;
  cell_t        val_q,       val_d;
  logic [4:0]   probe_q,     probe_d;
  logic         pass2_q,     pass2_d;
  logic         is_new_q,    is_new_d;
  board_t       board_out_q, board_out_d;
  logic         win_q,       win_d;
  logic         go_q,        go_d;
  logic         busy_q,      busy_d;
  logic         done_q,      done_d;

  logic         changed_s;
  logic         win_next_s;
  logic         any_empty_s;
  logic         any_pair_s;
  logic         go_next_s;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_s)
  );

  // Board evaluation: a win tile anywhere, or a full board with no mergeable neighbours.
  always_comb begin
    win_next_s  = 1'b0;
    any_empty_s = 1'b0;
    any_pair_s  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      win_next_s  = win_next_s  | (work_q[i] == CELL_WIN);
      any_empty_s = any_empty_s | (work_q[i] == CELL_EMPTY);
    end
    // Horizontal pairs stay within a row; vertical pairs are 4 cells apart.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        any_pair_s = any_pair_s | (work_q[4*r+c] == work_q[4*r+c+1]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      any_pair_s = any_pair_s | (work_q[i] == work_q[i+4]);
    end
    go_next_s = ~any_empty_s & ~any_pair_s;
  end

  // Next-state and datapath updates for the spawn sequence.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    ptr_d       = ptr_q;
    val_d       = val_q;
    probe_d     = probe_q;
    pass2_d     = pass2_q;
    is_new_d    = is_new_q;
    board_out_d = board_out_q;
    win_d       = win_q;
    go_d        = go_q;
    changed_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.new_game) begin
          is_new_d = 1'b1;
          state_d  = ST_LOAD;
        end else if (bus.start) begin
          is_new_d = 1'b0;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_LOAD: begin
        ptr_d   = lfsr_s[3:0];
        val_d   = spawn_val(lfsr_s[7:4]);
        probe_d = 5'd0;
        if (is_new_q) begin
          work_d    = '0;
          changed_s = 1'b1;
          pass2_d   = 1'b1;
          win_d     = 1'b0;
          go_d      = 1'b0;
        end else begin
          work_d    = bus.board_in;
          changed_s = (bus.board_in != bus.board_prev);
          pass2_d   = 1'b0;
        end
        state_d = changed_s ? ST_SEARCH : ST_CHECK;
      end

      ST_SEARCH: begin
        if (work_q[ptr_q] == CELL_EMPTY) begin
          work_d[ptr_q] = val_q;
          if (pass2_q) begin
            // Second new-game tile: fresh position and value, the first cell is now occupied.
            pass2_d = 1'b0;
            ptr_d   = lfsr_s[3:0];
            val_d   = spawn_val(lfsr_s[7:4]);
            probe_d = 5'd0;
            state_d = ST_SEARCH;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          ptr_d   = ptr_q + 4'd1;
          probe_d = probe_q + 5'd1;
          if (probe_q == 5'd15) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SEARCH;
          end
        end
      end

      ST_CHECK: begin
        board_out_d = work_q;
        win_d       = win_q | win_next_s;
        go_d        = go_q | go_next_s;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      ptr_q       <= 4'd0;
      val_q       <= CELL_EMPTY;
      probe_q     <= 5'd0;
      pass2_q     <= 1'b0;
      is_new_q    <= 1'b0;
      board_out_q <= '0;
      win_q       <= 1'b0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      ptr_q       <= ptr_d;
      val_q       <= val_d;
      probe_q     <= probe_d;
      pass2_q     <= pass2_d;
      is_new_q    <= is_new_d;
      board_out_q <= board_out_d;
      win_q       <= win_d;
      go_q        <= go_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.board_out = board_out_q;
  assign bus.win       = win_q;
  assign bus.game_over = go_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Randomised scoreboard bench for tile_spawner against a cell-level reference model.
module tb_tile_spawner;
  import game_pkg::*;

  typedef struct {
    board_t b;
    logic   w;
    logic   g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  tile_spawner_if bus();

  tile_spawner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  logic m_win = 1'b0;
  logic m_go = 1'b0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  // Reference random source, stepped on the same clock as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic cell_t spawn_of(input logic [15:0] l);
    return (((l >> 4) & 16'd15) == 16'd15) ? 4'd2 : 4'd1;
  endfunction

  // Writes v at the first empty cell scanning from p; returns cells probed.
  function automatic int spawn_into(input board_t bi, input int p, input cell_t v, output board_t bo);
    bo = bi;
    for (int k = 0; k < 16; k++) begin
      if (bo[(p + k) % 16] == 4'd0) begin
        bo[(p + k) % 16] = v;
        return k + 1;
      end
    end
    return 16;
  endfunction

  function automatic logic has_win(input board_t b);
    for (int i = 0; i < 16; i++) if (b[i] == 4'd11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic is_over(input board_t b);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (b[4*r+c] == 4'd0) return 1'b0;
        if (c < 3 && b[4*r+c] == b[4*r+c+1]) return 1'b0;
        if (r < 3 && b[4*r+c] == b[4*(r+1)+c]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched to the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        check("board_out", 64'(bus.board_out), 64'(e.b));
        check("win", 64'(bus.win), 64'(e.w));
        check("game_over", 64'(bus.game_over), 64'(e.g));
      end
    end
  end

  task automatic issue(input logic do_start, input logic do_new, input board_t bin,
                       input board_t bprev, input logic poke);
    exp_t e;
    logic [15:0] l1, l2;
    board_t b, b1;
    int probes, exp_lat, lat;
    bus.board_in   = bin;
    bus.board_prev = bprev;
    bus.start      = do_start;
    bus.new_game   = do_new;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    l1 = m_lfsr;
    if (do_new) begin
      b1 = '0;
      b1[l1[3:0]] = spawn_of(l1);
      l2 = lfsr_next(l1);
      probes  = spawn_into(b1, int'(l2[3:0]), spawn_of(l2), b);
      exp_lat = probes + 4;
      m_win = 1'b0;
      m_go  = 1'b0;
    end else if (bin != bprev) begin
      probes  = spawn_into(bin, int'(l1[3:0]), spawn_of(l1), b);
      exp_lat = probes + 3;
    end else begin
      b = bin;
      exp_lat = 3;
    end
    m_win = m_win | has_win(b);
    m_go  = m_go | is_over(b);
    e.b = b;
    e.w = m_win;
    e.g = m_go;
    sb.push_back(e);
    lat = 1;
    check("busy_run", 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      bus.start = (poke && lat == 3) ? 1'b1 : 1'b0;
      check("busy_run", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    check("busy_idle", 64'(bus.busy), 64'd0);
    check("done_width", 64'(bus.done), 64'd0);
  endtask

  function automatic board_t rand_board();
    board_t b;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0)       b[i] = 4'd0;
      else if ($urandom_range(0, 40) == 0) b[i] = 4'd11;
      else                                 b[i] = 4'($urandom_range(1, 10));
    end
    return b;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    board_t b0, b1, chk;
    int d0;
    bus.start = 1'b0;
    bus.new_game = 1'b0;
    bus.board_in = '0;
    bus.board_prev = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_board_out", 64'(bus.board_out), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_win", 64'(bus.win), 64'd0);
    check("rst_game_over", 64'(bus.game_over), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // New game with a start poked while busy.
    d0 = done_cnt;
    issue(1'b0, 1'b1, '0, '0, 1'b1);
    check("new_game_done_count", 64'(done_cnt - d0), 64'd1);

    // Unchanged board passes straight through.
    b0 = '0;
    b0[0] = 4'd1;
    issue(1'b1, 1'b0, b0, b0, 1'b0);

    // Single empty cell at index 9.
    for (int i = 0; i < 16; i++) b0[i] = 4'((i % 10) + 1);
    b0[9] = 4'd0;
    issue(1'b1, 1'b0, b0, '0, 1'b0);

    // Full checkerboard: 16 fruitless probes, game over.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) chk[4*r+c] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
    issue(1'b1, 1'b0, chk, '0, 1'b0);

    // Win tile, then an unchanged start keeps the flag.
    issue(1'b0, 1'b1, '0, '0, 1'b0);
    b0 = '0;
    b0[5] = 4'd11;
    issue(1'b1, 1'b0, b0, '0, 1'b0);
    issue(1'b1, 1'b0, b0, b0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      b0 = rand_board();
      b1 = ($urandom_range(0, 1) == 0) ? b0 : rand_board();
      case ($urandom_range(0, 19))
        0, 1:    issue(1'b0, 1'b1, b0, b1, 1'b0);
        2:       issue(1'b1, 1'b1, b0, b1, 1'b0);
        default: issue(1'b1, 1'b0, b0, b1, 1'b0);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset during the second search cycle aborts the spawn.
    bus.board_in = chk;
    bus.board_prev = '0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_win = 1'b0;
    m_go = 1'b0;
    #1;
    check("abort_board_out", 64'(bus.board_out), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_idle_busy", 64'(bus.busy), 64'd0);

    // First request after reset runs normally.
    b0 = rand_board();
    issue(1'b1, 1'b0, b0, b0, 1'b0);
    b1 = rand_board();
    issue(1'b1, 1'b0, b1, b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
